// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
package hazard_pkg;

  // E-stage operand source select; encodings match the datapath mux.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file read
    FWD_W  = 2'b01,  // W-stage result
    FWD_M  = 2'b10   // M-stage ALU result
  } fwd_sel_t;

  // Miss sequencing states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    IMISS = 2'd2
  } ctrl_state_t;

  // ResultSrc encoding that marks a load in E.
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding comparator for one E-stage source operand.
// The M stage wins over W because it holds the younger write; x0 is never forwarded.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  // Pick the youngest in-flight producer of this operand.
  always_comb begin
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage cached core: bank enables,
// registered active-low bank flushes, E-stage forwarding selects, cache-miss
// sequencing and a stalled-fetch cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_d,
  input  logic [REG_ADDR_W-1:0] Rs2_d,
  input  logic [REG_ADDR_W-1:0] Rs1_e,
  input  logic [REG_ADDR_W-1:0] Rs2_e,
  input  logic [REG_ADDR_W-1:0] Rd_e,
  input  logic [1:0]            ResultSrc_e,
  input  logic                  PCSrc_e,
  input  logic [REG_ADDR_W-1:0] Rd_m,
  input  logic [REG_ADDR_W-1:0] Rd_w,
  input  logic                  RegWrite_m,
  input  logic                  RegWrite_w,
  input  logic                  dmiss_m,
  input  logic                  dready,
  input  logic                  imiss_f,
  input  logic                  iready,
  output logic                  en_f,
  output logic                  en_d,
  output logic                  en_e,
  output logic                  en_m,
  output logic                  en_w,
  output logic                  flush_n_d,
  output logic                  flush_n_e,
  output logic                  flush_n_w,
  output logic [1:0]            ForwardA_e,
  output logic [1:0]            ForwardB_e,
  output logic [DATA_WIDTH-1:0] stall_cycles
);

  ctrl_state_t           state_reg;
  logic                  flush_n_d_reg;
  logic                  flush_n_e_reg;
  logic                  flush_n_w_reg;
  logic [DATA_WIDTH-1:0] stall_cycles_reg;

  logic dmiss_stall;
  logic branch_flush;
  logic rd_e_hit;
  logic load_use;
  logic imiss_active;
  logic imiss_stall;

  // Classify this cycle's hazard; each event masks everything below it
  // (D-miss > branch > load-use > I-miss).
  always_comb begin
    // A new miss in M always stalls, even while another refill is
    // finishing; an outstanding D refill stalls until dready.
    dmiss_stall  = dmiss_m | ((state_reg == DMISS) & ~dready);
    // While everything is frozen the branch in E is held and re-presents
    // after the refill, so it is only acted on outside a D-miss stall.
    branch_flush = PCSrc_e & ~dmiss_stall;
    rd_e_hit     = (Rd_e != '0) & ((Rd_e == Rs1_d) | (Rd_e == Rs2_d));
    load_use     = (ResultSrc_e == RESULT_SRC_LOAD) & rd_e_hit
                   & ~dmiss_stall & ~PCSrc_e;
    imiss_active = (state_reg == IMISS) | ((state_reg == RUN) & imiss_f);
    imiss_stall  = imiss_active & ~dmiss_stall & ~branch_flush & ~load_use;
  end

  // Bank enables: D-miss freezes the whole pipe, load-use holds F/D,
  // I-miss holds only the PC while the back end drains.
  assign en_f = ~rst & ~dmiss_stall & ~load_use & ~imiss_stall;
  assign en_d = ~rst & ~dmiss_stall & ~load_use;
  assign en_e = ~rst & ~dmiss_stall;
  assign en_m = ~rst & ~dmiss_stall;
  assign en_w = ~rst & ~dmiss_stall;

  // Flushes come straight from flops; reset forces them active so every
  // bank is cleared while rst is held.
  assign flush_n_d = flush_n_d_reg & ~rst;
  assign flush_n_e = flush_n_e_reg & ~rst;
  assign flush_n_w = flush_n_w_reg & ~rst;

  // One comparator per E-stage source operand (0 = Rs1, 1 = Rs2).
  logic [REG_ADDR_W-1:0] rs_e [2];
  fwd_sel_t              fwd_sel [2];

  assign rs_e[0] = Rs1_e;
  assign rs_e[1] = Rs2_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
      ) u_fwd (
        .rs_e        (rs_e[gi]),
        .rd_m        (Rd_m),
        .rd_w        (Rd_w),
        .reg_write_m (RegWrite_m),
        .reg_write_w (RegWrite_w),
        .sel         (fwd_sel[gi])
      );
    end
  endgenerate

  assign ForwardA_e = rst ? FWD_RF : fwd_sel[0];
  assign ForwardB_e = rst ? FWD_RF : fwd_sel[1];

  // Miss sequencer plus the registered flush pulses (trigger in cycle n
  // holds the bank clear from edge n+1 to edge n+2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      flush_n_d_reg <= 1'b1;
      flush_n_e_reg <= 1'b1;
      flush_n_w_reg <= 1'b1;
    end else begin
      // D receives a bubble on a taken branch and on every I-miss stall.
      flush_n_d_reg <= ~(branch_flush | imiss_stall);
      // E receives a bubble on a taken branch and behind a load-use hold.
      flush_n_e_reg <= ~(branch_flush | load_use);
      // No hazard ever needs to kill the M/W bank; a D-miss hold just
      // re-writes the same value into the register file.
      flush_n_w_reg <= 1'b1;

      case (state_reg)
        RUN: begin
          if (dmiss_m) begin
            state_reg <= DMISS;
          end else if (imiss_f) begin
            state_reg <= IMISS;
          end
        end
        DMISS: begin
          // A miss arriving with dready starts a fresh refill.
          if (dready && !dmiss_m) begin
            state_reg <= RUN;
          end
        end
        IMISS: begin
          // A data miss overrides the instruction refill in progress.
          if (dmiss_m) begin
            state_reg <= DMISS;
          end else if (iready) begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  // Count every cycle the fetch stage is held; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (!en_f) begin
      stall_cycles_reg <= stall_cycles_reg + DATA_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each stimulus cycle pushes its
// hand-computed expectations, a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] Rs1_d = '0, Rs2_d = '0, Rs1_e = '0, Rs2_e = '0, Rd_e = '0;
  logic [1:0]    ResultSrc_e = '0;
  logic          PCSrc_e = 1'b0;
  logic [RW-1:0] Rd_m = '0, Rd_w = '0;
  logic          RegWrite_m = 1'b0, RegWrite_w = 1'b0;
  logic          dmiss_m = 1'b0, dready = 1'b0, imiss_f = 1'b0, iready = 1'b0;
  logic          en_f, en_d, en_e, en_m, en_w;
  logic          flush_n_d, flush_n_e, flush_n_w;
  logic [1:0]    ForwardA_e, ForwardB_e;
  logic [DW-1:0] stall_cycles;

  // Next-cycle input values, applied just after the rising edge.
  logic [RW-1:0] n_rs1_d, n_rs2_d, n_rs1_e, n_rs2_e, n_rd_e, n_rd_m, n_rd_w;
  logic [1:0]    n_rsrc;
  logic          n_pc, n_rw_m, n_rw_w, n_dmiss, n_dready, n_imiss, n_iready, n_rst;

  typedef struct {
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_id = 0;

  hazard_ctrl #(
    .DATA_WIDTH (DW),
    .REG_ADDR_W (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1_d        (Rs1_d),
    .Rs2_d        (Rs2_d),
    .Rs1_e        (Rs1_e),
    .Rs2_e        (Rs2_e),
    .Rd_e         (Rd_e),
    .ResultSrc_e  (ResultSrc_e),
    .PCSrc_e      (PCSrc_e),
    .Rd_m         (Rd_m),
    .Rd_w         (Rd_w),
    .RegWrite_m   (RegWrite_m),
    .RegWrite_w   (RegWrite_w),
    .dmiss_m      (dmiss_m),
    .dready       (dready),
    .imiss_f      (imiss_f),
    .iready       (iready),
    .en_f         (en_f),
    .en_d         (en_d),
    .en_e         (en_e),
    .en_m         (en_m),
    .en_w         (en_w),
    .flush_n_d    (flush_n_d),
    .flush_n_e    (flush_n_e),
    .flush_n_w    (flush_n_w),
    .ForwardA_e   (ForwardA_e),
    .ForwardB_e   (ForwardB_e),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic clr();
    n_rs1_d = '0; n_rs2_d = '0; n_rs1_e = '0; n_rs2_e = '0; n_rd_e = '0;
    n_rd_m = '0; n_rd_w = '0; n_rsrc = '0; n_pc = 1'b0;
    n_rw_m = 1'b0; n_rw_w = 1'b0; n_dmiss = 1'b0; n_dready = 1'b0;
    n_imiss = 1'b0; n_iready = 1'b0;
  endtask

  // Apply one cycle of inputs and queue what the DUT must show in it.
  // en = {f,d,e,m,w}, fl = {flush_n_d, flush_n_e, flush_n_w}.
  task automatic cyc(input logic [4:0] en, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [31:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = n_rst; Rs1_d = n_rs1_d; Rs2_d = n_rs2_d; Rs1_e = n_rs1_e;
    Rs2_e = n_rs2_e; Rd_e = n_rd_e; ResultSrc_e = n_rsrc; PCSrc_e = n_pc;
    Rd_m = n_rd_m; Rd_w = n_rd_w; RegWrite_m = n_rw_m; RegWrite_w = n_rw_w;
    dmiss_m = n_dmiss; dready = n_dready; imiss_f = n_imiss; iready = n_iready;
    e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = sc; e.id = vec_id;
    vec_id++;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, want);
    end
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        $display("vec %0d en=%b fl=%b fa=%b fb=%b sc=%0d", e.id,
                 {en_f, en_d, en_e, en_m, en_w},
                 {flush_n_d, flush_n_e, flush_n_w},
                 ForwardA_e, ForwardB_e, stall_cycles);
        chk("en", e.id, 32'({en_f, en_d, en_e, en_m, en_w}), 32'(e.en));
        chk("flush_n", e.id, 32'({flush_n_d, flush_n_e, flush_n_w}), 32'(e.fl));
        chk("fwd_a", e.id, 32'(ForwardA_e), 32'(e.fa));
        chk("fwd_b", e.id, 32'(ForwardB_e), 32'(e.fb));
        chk("stall_cycles", e.id, stall_cycles, e.sc);
      end
    end
  end

  initial begin
    clr();
    n_rst = 1'b1;
    cyc(5'b00000, 3'b000, 2'b00, 2'b00, 0);   // 0: in reset
    n_rst = 1'b0;
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 0);   // 1: released
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 0);   // 2

    // Load-use on Rs1, then bubble into E
    n_rsrc = 2'b01; n_rd_e = 5; n_rs1_d = 5;
    cyc(5'b00111, 3'b111, 2'b00, 2'b00, 0);   // 3
    clr();
    cyc(5'b11111, 3'b101, 2'b00, 2'b00, 1);   // 4
    n_rsrc = 2'b01;                            // load to x0: no hazard
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 1);   // 5
    n_rd_e = 9; n_rs2_d = 9;                   // load-use on Rs2
    cyc(5'b00111, 3'b111, 2'b00, 2'b00, 1);   // 6
    clr();
    cyc(5'b11111, 3'b101, 2'b00, 2'b00, 2);   // 7

    // Single-cycle branch
    n_pc = 1'b1;
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 2);   // 8
    clr();
    cyc(5'b11111, 3'b001, 2'b00, 2'b00, 2);   // 9
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 2);   // 10
    // Branch masks a simultaneous load-use
    n_pc = 1'b1; n_rsrc = 2'b01; n_rd_e = 5; n_rs1_d = 5;
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 2);   // 11
    clr();
    cyc(5'b11111, 3'b001, 2'b00, 2'b00, 2);   // 12

    // D-miss with branch held throughout
    n_dmiss = 1'b1; n_pc = 1'b1;
    cyc(5'b00000, 3'b111, 2'b00, 2'b00, 2);   // 13
    n_dmiss = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(5'b00000, 3'b111, 2'b00, 2'b00, 32'(3 + i)); // 14..19
    end
    n_dmiss = 1'b1; n_dready = 1'b1;           // new miss with dready
    cyc(5'b00000, 3'b111, 2'b00, 2'b00, 9);   // 20
    n_dmiss = 1'b0; n_dready = 1'b0;
    cyc(5'b00000, 3'b111, 2'b00, 2'b00, 10);  // 21
    n_dready = 1'b1;                           // resume, branch now taken
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 11);  // 22
    clr();
    cyc(5'b11111, 3'b001, 2'b00, 2'b00, 11);  // 23

    // I-miss for 4 stalled cycles
    n_imiss = 1'b1;
    cyc(5'b01111, 3'b111, 2'b00, 2'b00, 11);  // 24
    clr();
    cyc(5'b01111, 3'b011, 2'b00, 2'b00, 12);  // 25
    cyc(5'b01111, 3'b011, 2'b00, 2'b00, 13);  // 26
    n_iready = 1'b1;
    cyc(5'b01111, 3'b011, 2'b00, 2'b00, 14);  // 27
    clr();
    cyc(5'b11111, 3'b011, 2'b00, 2'b00, 15);  // 28
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 15);  // 29

    // Branch during I-miss, then D-miss takes over
    n_imiss = 1'b1;
    cyc(5'b01111, 3'b111, 2'b00, 2'b00, 15);  // 30
    clr(); n_pc = 1'b1;
    cyc(5'b11111, 3'b011, 2'b00, 2'b00, 16);  // 31
    clr();
    cyc(5'b01111, 3'b001, 2'b00, 2'b00, 16);  // 32: still IMISS
    n_dmiss = 1'b1;
    cyc(5'b00000, 3'b011, 2'b00, 2'b00, 17);  // 33
    clr();
    cyc(5'b00000, 3'b111, 2'b00, 2'b00, 18);  // 34: in DMISS

    // Asynchronous reset mid-miss, forwarding inputs active
    n_rst = 1'b1; n_rd_m = 7; n_rw_m = 1'b1; n_rs1_e = 7;
    cyc(5'b00000, 3'b000, 2'b00, 2'b00, 0);   // 35
    n_rst = 1'b0;
    cyc(5'b11111, 3'b111, 2'b10, 2'b00, 0);   // 36: RUN after release

    // Forwarding
    n_rd_w = 7; n_rw_w = 1'b1; n_rs2_e = 7;
    cyc(5'b11111, 3'b111, 2'b10, 2'b10, 0);   // 37: M beats W
    n_rw_m = 1'b0;
    cyc(5'b11111, 3'b111, 2'b01, 2'b01, 0);   // 38: W only
    n_rw_m = 1'b1; n_rd_m = 3; n_rs2_e = 3;
    cyc(5'b11111, 3'b111, 2'b01, 2'b10, 0);   // 39
    n_rd_m = 0; n_rd_w = 0; n_rs1_e = 0; n_rs2_e = 0;
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 0);   // 40: x0 never forwarded
    clr();
    cyc(5'b11111, 3'b111, 2'b00, 2'b00, 0);   // 41

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
